ma_mem_access_ctrl: RTL and testbench

- Memory-access (MA) stage controller of the RV32IM pipeline.
- Takes the load/store request held in the EX/MA register and drives a handshaked data-memory port.
- Holds the pipeline with BUSYWAIT until the access completes, then presents the aligned, sign/zero-extended load result on DATA_OUT.
- DATA_OUT is the producer side of the MA/WB register's DATA_OUT input.

---
 rtl/ma_mem_access_ctrl_if.sv | 31 +++
 rtl/ma_mem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_ma_mem_access_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ma_mem_access_ctrl_if.sv
// Pipeline-request and data-memory port bundle for the MA-stage access controller.
// master = the controller; slave = the pipeline/memory side that surrounds it.
interface ma_mem_access_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busywait;
  logic [31:0] data_out;
  logic        access_err;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    input  mem_read, mem_write, funct3, address, store_data, dmem_rdata, dmem_ready,
    output busywait, data_out, access_err, dmem_read, dmem_write, dmem_addr,
           dmem_wdata, dmem_byte_en
  );

  modport slave (
    output mem_read, mem_write, funct3, address, store_data, dmem_rdata, dmem_ready,
    input  busywait, data_out, access_err, dmem_read, dmem_write, dmem_addr,
           dmem_wdata, dmem_byte_en
  );
endinterface

// File: rtl/ma_mem_access_ctrl.sv
// MA-stage load/store controller: issues one handshaked data-memory access per request.
// Latency: request cycle + N WAIT cycles + 1 DONE cycle (min 3); timeout after MAX_WAIT WAIT cycles.
// Backpressure: busywait stalls the pipeline until DONE; dmem strobes held until dmem_ready.
module ma_mem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  ma_mem_access_ctrl_if.master   ma
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        err_flag;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] data_out_q;
  logic        dmem_read_q;
  logic        dmem_write_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [3:0]  dmem_byte_en_q;

  logic        req;
  logic        f3_legal;
  logic        misaligned;
  logic        req_ok;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  assign req    = ma.mem_read | ma.mem_write;
  assign req_ok = (ma.mem_read ^ ma.mem_write) & f3_legal & ~misaligned;

  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    case (ma.funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ma.mem_read;  // unsigned forms exist only for loads
      default:                f3_legal = 1'b0;
    endcase
    case (ma.funct3[1:0])
      2'b01:   misaligned = ma.address[0];
      2'b10:   misaligned = |ma.address[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = ma.store_data;
    case (ma.funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << ma.address[1:0];
        wdata_nxt = {4{ma.store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << ma.address[1:0];
        wdata_nxt = {2{ma.store_data[15:0]}};
      end
      default: ;
    endcase
    if (ma.mem_read) be_nxt = 4'b1111;
  end

  // Shift the addressed lane down to bit 0, then extend by the latched size/sign.
  assign rd_shifted = ma.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_ext = {24'd0, rd_shifted[7:0]};
      3'b101:  load_ext = {16'd0, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      wait_cnt       <= 8'd0;
      err_flag       <= 1'b0;
      f3_q           <= 3'd0;
      off_q          <= 2'd0;
      data_out_q     <= 32'd0;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_addr_q    <= 32'd0;
      dmem_wdata_q   <= 32'd0;
      dmem_byte_en_q <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_ok) begin
              state          <= ST_WAIT;
              wait_cnt       <= 8'd0;
              f3_q           <= ma.funct3;
              off_q          <= ma.address[1:0];
              dmem_addr_q    <= {ma.address[31:2], 2'b00};
              dmem_byte_en_q <= be_nxt;
              dmem_wdata_q   <= wdata_nxt;
              dmem_read_q    <= ma.mem_read;
              dmem_write_q   <= ma.mem_write;
            end else begin
              state      <= ST_DONE;
              err_flag   <= 1'b1;
              data_out_q <= 32'd0;
            end
          end
        end
        ST_WAIT: begin
          if (ma.dmem_ready) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            if (dmem_read_q) data_out_q <= load_ext;
            state <= ST_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            data_out_q   <= 32'd0;
            err_flag     <= 1'b1;
            state        <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          err_flag <= 1'b0;
          wait_cnt <= 8'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ma.busywait     = ~reset & (((state == ST_IDLE) & req) | (state == ST_WAIT));
  assign ma.access_err   = (state == ST_DONE) & err_flag;
  assign ma.data_out     = data_out_q;
  assign ma.dmem_read    = dmem_read_q;
  assign ma.dmem_write   = dmem_write_q;
  assign ma.dmem_addr    = dmem_addr_q;
  assign ma.dmem_wdata   = dmem_wdata_q;
  assign ma.dmem_byte_en = dmem_byte_en_q;

endmodule

// File: tb/tb_ma_mem_access_ctrl.sv
// Directed-vector bench for ma_mem_access_ctrl (MAX_WAIT=4), plus timeout/reset/ready-ordering sequences.
module tb_ma_mem_access_ctrl;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ma_mem_access_ctrl_if ma ();

  ma_mem_access_ctrl #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ma    (ma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ready_at;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                     input int ready_at, input logic exp_err, input logic [31:0] exp_addr,
                     input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_data);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata;
    v.rdata = rdata; v.ready_at = ready_at; v.exp_err = exp_err; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_data = exp_data;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    ma.mem_read   = 1'b0;
    ma.mem_write  = 1'b0;
    ma.funct3     = 3'd0;
    ma.address    = 32'd0;
    ma.store_data = 32'd0;
    ma.dmem_ready = 1'b0;
  endtask

  // Entered and left on a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    ma.mem_read   = v.rd;
    ma.mem_write  = v.wr;
    ma.funct3     = v.f3;
    ma.address    = v.addr;
    ma.store_data = v.sdata;
    ma.dmem_rdata = v.rdata;
    ma.dmem_ready = 1'b0;
    #1 chk({v.name, " busy_req"}, ma.busywait, 1'b1);
    @(negedge clk);
    if (!v.exp_err) begin
      for (int w = 1; w <= v.ready_at; w++) begin
        chk({v.name, " busy_wait"}, ma.busywait, 1'b1);
        chk({v.name, " rd_strobe"}, ma.dmem_read, v.rd);
        chk({v.name, " wr_strobe"}, ma.dmem_write, v.wr);
        if (w == 1) begin
          chk({v.name, " addr"}, ma.dmem_addr, v.exp_addr);
          chk({v.name, " byte_en"}, ma.dmem_byte_en, v.exp_be);
          if (v.wr) chk({v.name, " wdata"}, ma.dmem_wdata, v.exp_wdata);
        end
        ma.dmem_ready = (w == v.ready_at);
        @(negedge clk);
      end
      ma.dmem_ready = 1'b0;
    end
    chk({v.name, " done_busy"}, ma.busywait, 1'b0);
    chk({v.name, " done_err"}, ma.access_err, v.exp_err);
    chk({v.name, " done_strobes"}, {ma.dmem_read, ma.dmem_write}, 2'b00);
    chk({v.name, " data_out"}, ma.data_out, v.exp_data);
    ma.mem_read  = 1'b0;
    ma.mem_write = 1'b0;
    @(negedge clk);
    chk({v.name, " idle_err"}, ma.access_err, 1'b0);
    chk({v.name, " idle_noreissue"}, {ma.busywait, ma.dmem_read, ma.dmem_write}, 3'b000);
    chk({v.name, " data_hold"}, ma.data_out, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //   name      rd wr f3      addr          sdata         rdata         rdy err exp_addr      be       wdata         data_out
    add("lb",      1, 0, 3'b000, 32'h0000_0102, 32'h0,        32'h12F4_5678, 2, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FFF4);
    add("lhu",     1, 0, 3'b101, 32'h0000_0202, 32'h0,        32'h8001_ABCD, 1, 0, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_8001);
    add("lw",      1, 0, 3'b010, 32'h0000_0200, 32'h0,        32'h8001_ABCD, 3, 0, 32'h0000_0200, 4'b1111, 32'h0,        32'h8001_ABCD);
    add("sb",      0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0,        2, 0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h8001_ABCD);
    add("sh",      0, 1, 3'b001, 32'h0000_0102, 32'h1234_CAFE, 32'h0,        1, 0, 32'h0000_0100, 4'b1100, 32'hCAFE_CAFE, 32'h8001_ABCD);
    add("lh",      1, 0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_8765, 1, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8765);
    add("lbu_last",1, 0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_9A00, 4, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_009A);
    add("sw",      0, 1, 3'b010, 32'h0000_010C, 32'hDEAD_BEEF, 32'h0,        1, 0, 32'h0000_010C, 4'b1111, 32'hDEAD_BEEF, 32'h0000_009A);
    add("lw_mis",  1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("lh_mis",  1, 0, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("f3_011",  1, 0, 3'b011, 32'h0000_0200, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("sbu_ill", 0, 1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("rd_wr",   1, 1, 3'b010, 32'h0000_0200, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("lb_top",  1, 0, 3'b000, 32'h0000_0003, 32'h0,        32'h8000_0000, 1, 0, 32'h0000_0000, 4'b1111, 32'h0,        32'hFFFF_FF80);
    add("sb_low",  0, 1, 3'b000, 32'h0000_0000, 32'h0000_0055, 32'h0,        2, 0, 32'h0000_0000, 4'b0001, 32'h5555_5555, 32'hFFFF_FF80);

    idle_inputs();
    ma.dmem_rdata = 32'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", ma.busywait, 1'b0);
    chk("rst_data", ma.data_out, 32'd0);
    chk("rst_strobes", {ma.dmem_read, ma.dmem_write, ma.access_err}, 3'b000);
    chk("rst_addr_be", {ma.dmem_addr, ma.dmem_byte_en}, 36'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vq[i]) run_vec(vq[i]);

    // Timeout: LW with no ready; strobe must last exactly MAX_WAIT cycles.
    ma.mem_read = 1'b1; ma.funct3 = 3'b010; ma.address = 32'h0000_0300;
    @(negedge clk);
    n = 0;
    while (ma.dmem_read && n < 20) begin
      n++;
      chk("to_busy", ma.busywait, 1'b1);
      @(negedge clk);
    end
    chk("to_rd_cycles", n, 4);
    chk("to_err", ma.access_err, 1'b1);
    chk("to_data", ma.data_out, 32'd0);
    chk("to_busy_drop", ma.busywait, 1'b0);
    ma.mem_read = 1'b0;
    @(negedge clk);
    chk("to_idle_err", ma.access_err, 1'b0);

    // dmem_ready while idle must not affect the next access.
    ma.dmem_ready = 1'b1;
    @(negedge clk);
    chk("rdy_idle_quiet", {ma.busywait, ma.dmem_read, ma.access_err}, 3'b000);
    ma.mem_read = 1'b1; ma.funct3 = 3'b010; ma.address = 32'h0000_0400;
    ma.dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("rdy_w1_rd", ma.dmem_read, 1'b1);
    ma.dmem_ready = 1'b0;
    @(negedge clk);
    chk("rdy_w2_rd", ma.dmem_read, 1'b1);
    ma.dmem_ready = 1'b1;
    @(negedge clk);
    ma.dmem_ready = 1'b0;
    chk("rdy_data", ma.data_out, 32'h1122_3344);
    chk("rdy_err", ma.access_err, 1'b0);
    ma.mem_read = 1'b0;
    @(negedge clk);

    // Reset in the second WAIT cycle aborts the access with no DONE cycle.
    ma.mem_read = 1'b1; ma.funct3 = 3'b010; ma.address = 32'h0000_0500;
    ma.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw_w1_rd", ma.dmem_read, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_busy", ma.busywait, 1'b0);
    chk("rw_strobes", {ma.dmem_read, ma.dmem_write, ma.access_err}, 3'b000);
    chk("rw_data", ma.data_out, 32'd0);
    chk("rw_addr", ma.dmem_addr, 32'd0);
    chk("rw_be_wdata", {ma.dmem_byte_en, ma.dmem_wdata}, 36'd0);
    ma.mem_read = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_idle", {ma.busywait, ma.dmem_read, ma.access_err}, 3'b000);
    begin
      vec_t v;
      v.name = "lw_after_rst"; v.rd = 1'b1; v.wr = 1'b0; v.f3 = 3'b010;
      v.addr = 32'h0000_0504; v.sdata = 32'h0; v.rdata = 32'h0BAD_C0DE; v.ready_at = 1;
      v.exp_err = 1'b0; v.exp_addr = 32'h0000_0504; v.exp_be = 4'b1111;
      v.exp_wdata = 32'h0; v.exp_data = 32'h0BAD_C0DE;
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
